sprite_compositor: RTL and testbench



---
 rtl/sprite_pkg.sv | 22 ++
 rtl/sprite_slot.sv | 93 +++++++++
 rtl/sprite_compositor.sv | 132 +++++++++++++
 tb/tb_sprite_compositor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types, register offsets and colour helpers for the sprite compositor.
package sprite_pkg;

    typedef logic [15:0] rgb565_t;
    typedef logic [23:0] rgb888_t;

    localparam logic [1:0] REG_X       = 2'd0;
    localparam logic [1:0] REG_Y       = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [8:0] REG_SKY     = 9'h100;
    localparam logic [8:0] REG_GROUND  = 9'h101;
    localparam logic [8:0] REG_HORIZON = 9'h102;

    localparam int H_ACTIVE_PIX = 640;
    localparam int V_ACTIVE     = 480;

    // Replicate the top bits so full-scale 565 maps to full-scale 888.
    function automatic rgb888_t expand565(input rgb565_t c);
        return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: pending/active position and control, hit test and ROM address.
// Active registers only change on the per-frame commit so a sprite never tears.
module sprite_slot
    import sprite_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int SPR_W   = 32,
    parameter int SPR_H   = 32,
    parameter int FRAMES  = 4,
    parameter int ADDR_W  = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [1:0]        i_wr_off,
    input  logic [31:0]       i_wr_data,
    input  logic              i_commit,
    input  logic [9:0]        i_px,
    input  logic [9:0]        i_py,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_addr
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam int FW = $clog2(FRAMES);
    localparam int DW = COORD_W + 1;

    logic [COORD_W-1:0] r_pend_x;
    logic [COORD_W-1:0] r_pend_y;
    logic               r_pend_en;
    logic [FW-1:0]      r_pend_frame;
    logic [COORD_W-1:0] r_act_x;
    logic [COORD_W-1:0] r_act_y;
    logic               r_act_en;
    logic [FW-1:0]      r_act_frame;
    logic [ADDR_W-1:0]  r_addr;
    logic [DW-1:0]      w_dx;
    logic [DW-1:0]      w_dy;
    logic               w_unused_data;

    // The extra bit makes pixels left of / above the sprite look huge, never a hit.
    assign w_dx  = DW'(i_px) - DW'(r_act_x);
    assign w_dy  = DW'(i_py) - DW'(r_act_y);
    assign o_hit = r_act_en && (w_dx < DW'(SPR_W)) && (w_dy < DW'(SPR_H));
    assign o_addr = r_addr;
    assign w_unused_data = ^i_wr_data;

    // Host-visible pending registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_x     <= '0;
            r_pend_y     <= '0;
            r_pend_en    <= 1'b0;
            r_pend_frame <= '0;
        end else if (i_wr_en) begin
            case (i_wr_off)
                REG_X:    r_pend_x <= i_wr_data[COORD_W-1:0];
                REG_Y:    r_pend_y <= i_wr_data[COORD_W-1:0];
                REG_CTRL: begin
                    r_pend_en    <= i_wr_data[0];
                    r_pend_frame <= i_wr_data[FW:1];
                end
                default: ;
            endcase
        end
    end

    // Active registers, loaded from the pre-write pending values at commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_x     <= '0;
            r_act_y     <= '0;
            r_act_en    <= 1'b0;
            r_act_frame <= '0;
        end else if (i_commit) begin
            r_act_x     <= r_pend_x;
            r_act_y     <= r_pend_y;
            r_act_en    <= r_pend_en;
            r_act_frame <= r_pend_frame;
        end
    end

    // ROM address; held on a miss so the ROM is not needlessly re-addressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
        end else if (o_hit) begin
            r_addr <= ADDR_W'({r_act_frame, w_dy[RW-1:0], w_dx[CW-1:0]});
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// N-slot sprite compositor: per-slot ROM addressing, colour-key transparency and
// index priority over a sky/ground background. frame_start is registered, so it is
// high during the cycle after vcount==480 && hcount==0 was presented.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int          NUM_SPRITES = 8,
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          FRAMES      = 4,
    parameter int          COORD_W     = 10,
    parameter logic [15:0] TRANSP_KEY  = 16'hF81F,
    parameter int          ADDR_W      = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic [8:0]                    address,
    input  logic [31:0]                   writedata,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    input  logic                          blank_n,
    output logic [NUM_SPRITES*ADDR_W-1:0] spr_addr,
    input  logic [NUM_SPRITES*16-1:0]     spr_data,
    output logic [23:0]                   rgb,
    output logic                          frame_start
);

    logic                   w_wr;
    logic                   w_commit;
    logic [9:0]             w_px;
    logic [9:0]             w_py;
    logic [NUM_SPRITES-1:0] w_hit;
    logic [23:0]            r_pend_sky;
    logic [23:0]            r_pend_gnd;
    logic [9:0]             r_pend_hor;
    logic [23:0]            r_act_sky;
    logic [23:0]            r_act_gnd;
    logic [9:0]             r_act_hor;
    logic [NUM_SPRITES-1:0] r_hit_d;
    logic                   r_blank_d;
    logic [23:0]            r_bg_d;
    rgb888_t                w_colour;
    logic [23:0]            r_rgb;
    logic                   r_frame_start;
    logic                   w_unused;

    assign w_wr        = chipselect && write;
    assign w_px        = hcount[10:1];
    assign w_py        = vcount;
    assign w_commit    = (vcount == 10'(V_ACTIVE)) && (hcount == 11'd0);
    assign rgb         = r_rgb;
    assign frame_start = r_frame_start;
    assign w_unused    = ^{hcount[0], writedata[31:24]};

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
            sprite_slot #(
                .COORD_W (COORD_W),
                .SPR_W   (SPR_W),
                .SPR_H   (SPR_H),
                .FRAMES  (FRAMES),
                .ADDR_W  (ADDR_W)
            ) u_slot (
                .clk       (clk),
                .reset     (reset),
                .i_wr_en   (w_wr && (address[8:2] == 7'(gi))),
                .i_wr_off  (address[1:0]),
                .i_wr_data (writedata),
                .i_commit  (w_commit),
                .i_px      (w_px),
                .i_py      (w_py),
                .o_hit     (w_hit[gi]),
                .o_addr    (spr_addr[gi*ADDR_W +: ADDR_W])
            );
        end
    endgenerate

    // Background colours and horizon, double-buffered like the slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_sky <= 24'h0000FF;
            r_pend_gnd <= 24'hFFFFFF;
            r_pend_hor <= 10'd200;
            r_act_sky  <= 24'h0000FF;
            r_act_gnd  <= 24'hFFFFFF;
            r_act_hor  <= 10'd200;
        end else begin
            if (w_commit) begin
                r_act_sky <= r_pend_sky;
                r_act_gnd <= r_pend_gnd;
                r_act_hor <= r_pend_hor;
            end
            if (w_wr) begin
                case (address)
                    REG_SKY:     r_pend_sky <= writedata[23:0];
                    REG_GROUND:  r_pend_gnd <= writedata[23:0];
                    REG_HORIZON: r_pend_hor <= writedata[9:0];
                    default: ;
                endcase
            end
        end
    end

    // Highest-index opaque hit wins; later iterations override earlier ones.
    always_comb begin
        w_colour = r_bg_d;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_colour = (r_hit_d[i] && (spr_data[i*16 +: 16] != TRANSP_KEY))
                       ? expand565(spr_data[i*16 +: 16]) : w_colour;
        end
    end

    // S0 side-band registers alongside the ROM address, then the S1 output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_d       <= '0;
            r_blank_d     <= 1'b0;
            r_bg_d        <= 24'h000000;
            r_rgb         <= 24'h000000;
            r_frame_start <= 1'b0;
        end else begin
            r_hit_d       <= w_hit;
            r_blank_d     <= blank_n;
            r_bg_d        <= (w_py < r_act_hor) ? r_act_sky : r_act_gnd;
            r_rgb         <= r_blank_d ? w_colour : 24'h000000;
            r_frame_start <= w_commit;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised bench for sprite_compositor against a pixel-level behavioural model,
// with a few directed scenarios pinned to hand-computed values.
module tb_sprite_compositor;

    localparam int          NS  = 8;
    localparam int          AW  = 12;
    localparam logic [15:0] KEY = 16'hF81F;

    logic             clk = 1'b0;
    logic             reset;
    logic             chipselect;
    logic             write;
    logic [8:0]       address;
    logic [31:0]      writedata;
    logic [10:0]      hcount;
    logic [9:0]       vcount;
    logic             blank_n;
    logic [NS*AW-1:0] spr_addr;
    logic [NS*16-1:0] spr_data;
    logic [23:0]      rgb;
    logic             frame_start;

    int tests  = 0;
    int failed = 0;

    bit          f_en[NS];
    logic [15:0] f_dat[NS];

    // Model state: pending/active registers, per-slot held address, one pipeline stage.
    int          p_x[NS], p_y[NS], p_fr[NS], a_x[NS], a_y[NS], a_fr[NS];
    bit          p_en[NS], a_en[NS];
    logic [23:0] p_sky, p_gnd, a_sky, a_gnd;
    int          p_hor, a_hor;
    int          e_addr[NS];
    bit          h_hit[NS];
    bit          h_blank;
    logic [23:0] h_bg;
    logic [23:0] e_rgb;
    bit          e_fs;

    sprite_compositor dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .hcount      (hcount),
        .vcount      (vcount),
        .blank_n     (blank_n),
        .spr_addr    (spr_addr),
        .spr_data    (spr_data),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] rom_fn(input int slot, input logic [11:0] a,
                                           input bit fen, input logic [15:0] fd);
        int h;
        if (fen) return fd;
        h = int'(a) * 97 + slot * 4099;
        if (h % 6 == 1) return KEY;
        return 16'(h * 13 + 4660);
    endfunction

    always_comb begin
        spr_data = '0;
        for (int i = 0; i < NS; i++)
            spr_data[i*16 +: 16] = rom_fn(i, spr_addr[i*AW +: AW], f_en[i], f_dat[i]);
    end

    function automatic logic [23:0] to888(input logic [15:0] c);
        int r, g, b;
        r = int'(c[15:11]);
        g = int'(c[10:5]);
        b = int'(c[4:0]);
        return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int px, py, a, s;
        bit found;
        bit nh[NS];
        logic [15:0] d;
        logic [23:0] col;
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                p_x[i] = 0; p_y[i] = 0; p_fr[i] = 0; p_en[i] = 0;
                a_x[i] = 0; a_y[i] = 0; a_fr[i] = 0; a_en[i] = 0;
                e_addr[i] = 0; h_hit[i] = 0;
            end
            p_sky = 24'h0000FF; p_gnd = 24'hFFFFFF; p_hor = 200;
            a_sky = 24'h0000FF; a_gnd = 24'hFFFFFF; a_hor = 200;
            h_blank = 0; h_bg = 24'h0; e_rgb = 24'h0; e_fs = 0;
        end else begin
            col = h_bg;
            found = 0;
            for (int i = NS - 1; i >= 0; i--) begin
                if (!found && h_hit[i]) begin
                    d = rom_fn(i, 12'(e_addr[i]), f_en[i], f_dat[i]);
                    if (d != KEY) begin
                        col = to888(d);
                        found = 1;
                    end
                end
            end
            e_rgb = h_blank ? col : 24'h0;
            px = int'(hcount) / 2;
            py = int'(vcount);
            for (int i = 0; i < NS; i++) begin
                nh[i] = a_en[i] && px >= a_x[i] && px < a_x[i] + 32 &&
                        py >= a_y[i] && py < a_y[i] + 32;
                if (nh[i]) e_addr[i] = a_fr[i] * 1024 + (py - a_y[i]) * 32 + (px - a_x[i]);
                h_hit[i] = nh[i];
            end
            h_bg = (py < a_hor) ? a_sky : a_gnd;
            h_blank = blank_n;
            e_fs = (vcount == 10'd480) && (hcount == 11'd0);
            if (e_fs) begin
                for (int i = 0; i < NS; i++) begin
                    a_x[i] = p_x[i]; a_y[i] = p_y[i]; a_fr[i] = p_fr[i]; a_en[i] = p_en[i];
                end
                a_sky = p_sky; a_gnd = p_gnd; a_hor = p_hor;
            end
            if (chipselect && write) begin
                a = int'(address);
                if (a < NS * 4) begin
                    s = a / 4;
                    case (a % 4)
                        0: p_x[s] = int'(writedata[9:0]);
                        1: p_y[s] = int'(writedata[9:0]);
                        2: begin
                            p_en[s] = writedata[0];
                            p_fr[s] = int'((writedata >> 1) & 32'd3);
                        end
                        default: ;
                    endcase
                end else if (a == 256) p_sky = writedata[23:0];
                else if (a == 257) p_gnd = writedata[23:0];
                else if (a == 258) p_hor = int'(writedata[9:0]);
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("rgb", rgb, e_rgb);
        chk("frame_start", frame_start, e_fs);
        for (int i = 0; i < NS; i++)
            chk($sformatf("spr_addr%0d", i), spr_addr[i*AW +: AW], e_addr[i]);
    endtask

    task automatic pix(input int x, input int y);
        hcount  = 11'(x * 2);
        vcount  = 10'(y);
        blank_n = (x < 640) && (y < 480);
    endtask

    task automatic pstep(input int x, input int y);
        pix(x, y);
        step();
    endtask

    task automatic wr(input int a, input int d);
        address = 9'(a); writedata = 32'(d);
        chipselect = 1; write = 1;
        step();
        chipselect = 0; write = 0;
    endtask

    task automatic commit();
        hcount = 11'd0; vcount = 10'd480; blank_n = 0;
        step();
        hcount = 11'd44; vcount = 10'd490;
    endtask

    initial begin
        int px, py, s, o, k;
        reset = 1; chipselect = 0; write = 0; address = '0; writedata = '0;
        for (int i = 0; i < NS; i++) begin f_en[i] = 0; f_dat[i] = 16'h0; end
        pix(0, 0);
        step();
        step();
        chk("reset_rgb", rgb, 24'h0);
        reset = 0;

        pstep(10, 100); pstep(11, 100);
        chk("sky_line100", rgb, 24'h0000FF);
        pstep(10, 300); pstep(11, 300);
        chk("ground_line300", rgb, 24'hFFFFFF);
        hcount = 11'd1300; vcount = 10'd100; blank_n = 0; step(); step();
        chk("blanked", rgb, 24'h0);

        wr(0, 100); wr(1, 50); wr(2, 1); commit();
        pstep(100, 50); chk("slot0_first", spr_addr[0 +: AW], 0);
        pstep(131, 81); chk("slot0_last", spr_addr[0 +: AW], 1023);
        pstep(132, 81); chk("slot0_hold", spr_addr[0 +: AW], 1023);
        pstep(133, 81); chk("right_of_sprite", rgb, 24'h0000FF);

        wr(0, 190); wr(1, 190); wr(12, 200); wr(13, 200); wr(14, 1); commit();
        f_en[3] = 1; f_dat[3] = KEY; f_en[0] = 1; f_dat[0] = 16'hF800;
        pstep(200, 200); pstep(201, 200);
        chk("slot3_transparent", rgb, 24'hFF0000);
        f_dat[3] = 16'h07E0;
        pstep(200, 200); pstep(201, 200);
        chk("slot3_wins", rgb, 24'h00FF00);
        f_en[0] = 0; f_en[3] = 0;

        pix(5, 250); wr(12, 300);
        pstep(205, 203); chk("midframe_old_x", spr_addr[3*AW +: AW], 101);
        address = 9'd12; writedata = 32'd400; chipselect = 1; write = 1;
        hcount = 11'd0; vcount = 10'd480; blank_n = 0; step();
        chipselect = 0; write = 0;
        pstep(306, 203); chk("committed_x300", spr_addr[3*AW +: AW], 102);
        pstep(405, 203); chk("coincident_not_yet", spr_addr[3*AW +: AW], 102);
        commit();
        pstep(407, 203); chk("coincident_next", spr_addr[3*AW +: AW], 103);

        wr(4, 500); wr(5, 10); wr(6, 5); commit();
        pstep(500, 10); chk("frame2_addr", spr_addr[1*AW +: AW], 2048);
        wr(6, 11); commit();
        pstep(500, 10); chk("frame5_masked", spr_addr[1*AW +: AW], 1024);

        wr(8, 630); wr(9, 20); wr(10, 1); commit();
        pstep(639, 20); chk("clip_last_col", spr_addr[2*AW +: AW], 9);
        pstep(5, 20); chk("no_wrap_addr", spr_addr[2*AW +: AW], 9);
        pstep(6, 20); chk("no_wrap_rgb", rgb, 24'h0000FF);

        pix(50, 100); reset = 1; step(); reset = 0;
        chk("midframe_reset_rgb", rgb, 24'h0);
        for (int i = 0; i < NS; i++) chk($sformatf("reset_addr%0d", i), spr_addr[i*AW +: AW], 0);
        pstep(195, 195); pstep(196, 195);
        chk("slots_disabled", rgb, 24'h0000FF);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 599) == 0);
            chipselect = 0; write = 0;
            if ($urandom_range(0, 3) == 0) begin
                chipselect = ($urandom_range(0, 7) != 0);
                write = ($urandom_range(0, 7) != 0);
                k = $urandom_range(0, 9);
                if (k < 6) begin
                    s = $urandom_range(0, 15); o = $urandom_range(0, 3);
                    address = 9'(s * 4 + o);
                    writedata = (o < 2 && $urandom_range(0, 4) != 0) ? 32'($urandom_range(0, 330)) : $urandom;
                end else if (k < 9) begin
                    address = 9'(256 + $urandom_range(0, 2));
                    writedata = $urandom;
                end else begin
                    address = 9'($urandom);
                    writedata = $urandom;
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                hcount = 11'd0; vcount = 10'd480; blank_n = 0;
            end else begin
                px = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 799) : $urandom_range(0, 330);
                py = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 524) : $urandom_range(0, 330);
                hcount = 11'(px * 2 + $urandom_range(0, 1));
                vcount = 10'(py);
                blank_n = ((px < 640) && (py < 480)) ^ ($urandom_range(0, 9) == 0);
            end
            step();
        end
        reset = 0; chipselect = 0; write = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
